// File: rtl/mem_flush_seq.sv
// Memory-maintenance sequencer: serialises FENCE.I, SFENCE.VMA and exception
// cleanup through drain, L1D->L2 sync, TLB flush and MSHR clear phases.
module mem_flush_seq #(
    parameter int unsigned ASID_LEN     = 16,
    parameter int unsigned VPN_LEN      = 27,
    parameter int unsigned TIMEOUT_W    = 8,
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [1:0]          req_type_i,
    input  logic                req_asid_en_i,
    input  logic [ASID_LEN-1:0] req_asid_i,
    input  logic                req_vpn_en_i,
    input  logic [VPN_LEN-1:0]  req_vpn_i,
    input  logic                lsq_empty_i,
    input  logic                l2c_update_done_i,
    output logic                stall_o,
    output logic                synch_l1dc_l2c_o,
    output logic [1:0]          l1tlb_flush_type_o,
    output logic [1:0]          l2tlb_flush_type_o,
    output logic [ASID_LEN-1:0] flush_asid_o,
    output logic [VPN_LEN-1:0]  flush_page_o,
    output logic                clr_l1tlb_mshr_o,
    output logic                clr_l2tlb_mshr_o,
    output logic                clear_dmshr_dregs_o,
    output logic                flush_o,
    output logic                done_o,
    output logic                timeout_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRAIN = 3'd1;
    localparam logic [2:0] S_SYNC  = 3'd2;
    localparam logic [2:0] S_TLB   = 3'd3;
    localparam logic [2:0] S_CLEAR = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [1:0] T_FENCE_I  = 2'd0;
    localparam logic [1:0] T_SFENCE   = 2'd1;
    localparam logic [1:0] T_EXCEPT_I = 2'd2;
    localparam logic [1:0] T_EXCEPT_D = 2'd3;

    localparam logic [1:0] NO_FLUSH    = 2'd0;
    localparam logic [1:0] FLUSH_ALL   = 2'd1;
    localparam logic [1:0] FLUSH_ASID  = 2'd2;
    localparam logic [1:0] FLUSH_PAGE  = 2'd3;

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = TIMEOUT_W'(WAIT_TIMEOUT);

    logic [2:0]           state_q, state_d;
    logic [1:0]           type_q;
    logic                 asid_en_q, vpn_en_q;
    logic [ASID_LEN-1:0]  asid_q;
    logic [VPN_LEN-1:0]   vpn_q;
    logic [TIMEOUT_W-1:0] cnt_q;
    logic                 timeout_q;
    logic                 cnt_hit;
    logic [1:0]           flush_type;

    assign cnt_hit = (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid_i)
                         state_d = (req_type_i == T_EXCEPT_I || req_type_i == T_EXCEPT_D) ? S_CLEAR : S_DRAIN;
            S_DRAIN: if (lsq_empty_i || cnt_hit) state_d = S_SYNC;
            S_SYNC:  if (l2c_update_done_i || cnt_hit)
                         state_d = (type_q == T_SFENCE) ? S_TLB : S_CLEAR;
            S_TLB:   state_d = S_CLEAR;
            S_CLEAR: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            type_q    <= T_FENCE_I;
            asid_en_q <= 1'b0;
            vpn_en_q  <= 1'b0;
            asid_q    <= '0;
            vpn_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // Counter restarts on every state change and saturates otherwise.
            if (state_d != state_q) cnt_q <= '0;
            else if (!cnt_hit)      cnt_q <= cnt_q + 1'b1;

            if (state_q == S_IDLE && req_valid_i) begin
                type_q    <= req_type_i;
                asid_en_q <= req_asid_en_i;
                vpn_en_q  <= req_vpn_en_i;
                asid_q    <= req_asid_i;
                vpn_q     <= req_vpn_i;
                timeout_q <= 1'b0;
            end else if ((state_q == S_DRAIN && !lsq_empty_i && cnt_hit) ||
                         (state_q == S_SYNC && !l2c_update_done_i && cnt_hit)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    always_comb begin
        req_ready_o         = (state_q == S_IDLE);
        stall_o             = (state_q != S_IDLE);
        synch_l1dc_l2c_o    = (state_q == S_SYNC);
        flush_type          = NO_FLUSH;
        flush_asid_o        = '0;
        flush_page_o        = '0;
        clr_l1tlb_mshr_o    = 1'b0;
        clr_l2tlb_mshr_o    = 1'b0;
        clear_dmshr_dregs_o = 1'b0;
        flush_o             = 1'b0;
        done_o              = 1'b0;
        timeout_o           = 1'b0;
        case (state_q)
            S_TLB: begin
                if (vpn_en_q) begin
                    flush_type   = FLUSH_PAGE;
                    flush_page_o = vpn_q;
                    if (asid_en_q) flush_asid_o = asid_q;
                end else if (asid_en_q) begin
                    flush_type   = FLUSH_ASID;
                    flush_asid_o = asid_q;
                end else begin
                    flush_type   = FLUSH_ALL;
                end
            end
            S_CLEAR: begin
                case (type_q)
                    T_FENCE_I, T_EXCEPT_I: begin
                        clr_l1tlb_mshr_o = 1'b1;
                        clr_l2tlb_mshr_o = 1'b1;
                    end
                    T_SFENCE: begin
                        clr_l1tlb_mshr_o    = 1'b1;
                        clr_l2tlb_mshr_o    = 1'b1;
                        clear_dmshr_dregs_o = 1'b1;
                    end
                    T_EXCEPT_D: clear_dmshr_dregs_o = 1'b1;
                    default: ;
                endcase
            end
            S_DONE: begin
                done_o    = 1'b1;
                timeout_o = timeout_q;
                flush_o   = (type_q != T_SFENCE);
            end
            default: ;
        endcase
        l1tlb_flush_type_o = flush_type;
        l2tlb_flush_type_o = flush_type;
    end

endmodule

// File: doc/mem_flush_seq.md
Name: mem_flush_seq

Overview:
Sequencer that serialises memory-system maintenance operations: FENCE.I, SFENCE.VMA, and instruction- or data-side exception cleanup. It sits between the main control unit and the LSQ, L1 d-cache/L2 update unit, TLBs and MSHRs. It stalls the front end, drains outstanding loads/stores, synchronises L1D with L2, issues TLB flushes, and pulses MSHR clears in a fixed order. One operation is in flight at a time; completion is signalled with a single-cycle done.

Parameters:
ASID_LEN, 16, width of address-space ID
VPN_LEN, 27, width of virtual page number (Sv39)
TIMEOUT_W, 8, width of wait-timeout counter
WAIT_TIMEOUT, 255, max cycles spent in DRAIN or SYNC before forced advance

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
req_valid_i  in  1  maintenance request valid
req_ready_o  out  1  sequencer idle, request accepted when valid&ready
req_type_i  in  2  0=FENCE_I, 1=SFENCE_VMA, 2=EXCEPT_I, 3=EXCEPT_D
req_asid_en_i  in  1  SFENCE rs2!=x0
req_asid_i  in  ASID_LEN  ASID operand
req_vpn_en_i  in  1  SFENCE rs1!=x0
req_vpn_i  in  VPN_LEN  page operand
lsq_empty_i  in  1  LSQ has no pending memory ops
l2c_update_done_i  in  1  L1D->L2 synchronisation complete
stall_o  out  1  front-end/issue stall
synch_l1dc_l2c_o  out  1  request L1D->L2 synchronisation (level)
l1tlb_flush_type_o  out  2  NoFlush=0, FlushAll=1, FlushASID=2, FlushPage=3
l2tlb_flush_type_o  out  2  same encoding, always equal to L1 value
flush_asid_o  out  ASID_LEN  ASID for flush, 0 when not flushing
flush_page_o  out  VPN_LEN  VPN for flush, 0 when not flushing
clr_l1tlb_mshr_o  out  1  clear L1 TLB MSHR (pulse)
clr_l2tlb_mshr_o  out  1  clear L2 TLB MSHR (pulse)
clear_dmshr_dregs_o  out  1  clear d-cache MSHR/regs (pulse)
flush_o  out  1  pipeline flush (pulse)
done_o  out  1  operation complete (pulse)
timeout_o  out  1  valid with done_o: a wait state timed out

Behaviour:
- Reset: state IDLE. All outputs 0 or NoFlush except req_ready_o=1. Latched operands and counter cleared. A reset mid-operation abandons the operation, including an in-progress SYNC; no done_o is produced.
- All outputs are Moore-decoded from registered state and latched fields. No combinational path exists from req_* to any output.
- IDLE: req_ready_o=1, stall_o=0. On valid&ready, latch type/asid/vpn/enables, clear the sticky timeout flag, and move to DRAIN (FENCE_I/SFENCE_VMA) or CLEAR (EXCEPT_I/EXCEPT_D).
- req_ready_o=0 in every non-IDLE state. Requests arriving while busy are held by the requester; there is no queueing.
- stall_o=1 in every non-IDLE state.
- DRAIN: counter increments each cycle. Exit when lsq_empty_i=1, or when counter==WAIT_TIMEOUT (sets sticky timeout). Next state is SYNC for both FENCE_I and SFENCE_VMA.
- SYNC: synch_l1dc_l2c_o=1 for the whole state. Exit the cycle after l2c_update_done_i is sampled 1, or on timeout (sets sticky timeout). Next state: FENCE_I->CLEAR, SFENCE_VMA->TLB_FLUSH. Counter resets on every state entry.
- TLB_FLUSH (SFENCE only, 1 cycle):
  - vpn_en=1 -> FlushPage, flush_page_o=vpn, flush_asid_o=asid if asid_en else 0.
  - vpn_en=0, asid_en=1 -> FlushASID, flush_asid_o=asid.
  - both 0 -> FlushAll.
- CLEAR (1 cycle):
  - FENCE_I: clr_l1tlb+clr_l2tlb.
  - SFENCE_VMA: clr_l1tlb+clr_l2tlb+clear_dmshr.
  - EXCEPT_I: clr_l1tlb+clr_l2tlb.
  - EXCEPT_D: clear_dmshr.
- DONE (1 cycle): done_o=1. timeout_o=sticky flag. flush_o=1 for FENCE_I, EXCEPT_I and EXCEPT_D; flush_o=0 for SFENCE_VMA. Then IDLE. A request can be accepted at the earliest one cycle after DONE.
- Latency, measured from the accept cycle T:
  - SFENCE with lsq_empty and done already high: DRAIN T+1, SYNC T+2, TLB_FLUSH T+3, CLEAR T+4, DONE T+5, IDLE T+6.
  - EXCEPT: CLEAR T+1, DONE T+2.
- Counter saturates. A timeout in DRAIN does not skip SYNC.
- l2c_update_done_i is ignored outside SYNC. lsq_empty_i is ignored outside DRAIN.

Test Plan:
- Reset mid-SYNC (synch=1) -> next cycle synch=0, req_ready_o=1, no done_o. A subsequent FENCE_I completes normally.
- SFENCE asid_en=1 asid=0x5, vpn_en=0, lsq_empty=1, done high -> FlushASID with flush_asid_o=0x5 at T+3. CLEAR pulses all three clears at T+4. done_o at T+5 with flush_o=0.
- SFENCE vpn_en=1 vpn=0x1234, lsq_empty low for 10 cycles, l2c done after 3 SYNC cycles:
  - stall_o continuous.
  - synch_l1dc_l2c_o high exactly 3 cycles.
  - FlushPage with flush_page_o=0x1234.
  - done_o with timeout_o=0.
- EXCEPT_D accepted at T -> clear_dmshr_dregs_o only at T+1; done_o and flush_o at T+2; TLB flush types remain NoFlush throughout.
- FENCE_I with lsq_empty stuck 0, WAIT_TIMEOUT=255 -> leaves DRAIN after 256 cycles, enters SYNC. done_o asserts with timeout_o=1, flush_o=1.
- req_valid_i held high across an operation with a second request queued behind it -> second request accepted only in the IDLE cycle after DONE. req_ready_o=0 throughout the first operation.
